// File: rtl/dcache_pkg.sv
// Shared types and constants for the dcache load-side controller.
package dcache_pkg;
  localparam int NUM_LD     = 3;
  localparam int MSHR_DEPTH = 4;
  localparam int DC_IDX_W   = 5;
  localparam int DC_TAG_W   = 8;
  localparam int MEM_TAG_W  = 4;
  localparam int NUM_WR     = 3;
  localparam int LINE_W     = DC_TAG_W + DC_IDX_W;
  localparam int SLOT_W     = $clog2(MSHR_DEPTH);

  typedef enum logic [1:0] {BUS_NONE = 2'd0, BUS_LOAD = 2'd1} MEM_CMD;
  typedef enum logic [1:0] {MSHR_EMPTY, MSHR_WAIT_ISSUE, MSHR_WAIT_DATA} MSHR_STATE;

  // age: 0 = oldest live entry; live entries always hold distinct ages
  typedef struct packed {
    MSHR_STATE             state;
    logic [DC_TAG_W-1:0]   tag;
    logic [DC_IDX_W-1:0]   idx;
    logic [MEM_TAG_W-1:0]  mem_tag;
    logic [SLOT_W-1:0]     age;
  } mshr_entry_t;

  function automatic logic [31:0] ones(input logic [7:0] v);
    ones = '0;
    for (int i = 0; i < 8; i++) ones = ones + 32'(v[i]);
  endfunction
endpackage

// File: rtl/dcache_mshr_alloc.sv
// Per-cycle miss classification: merge into a live/earlier-port line, else
// take the lowest free MSHR in port order, else drop.
module dcache_mshr_alloc #(
  parameter int NUM_LD = 3,
  parameter int DEPTH  = 4,
  parameter int LINE_W = 13,
  parameter int SLOT_W = $clog2(DEPTH)
) (
  input  logic [NUM_LD-1:0]             miss,
  input  logic [NUM_LD-1:0][LINE_W-1:0] line,
  input  logic [DEPTH-1:0]              live,
  input  logic [DEPTH-1:0][LINE_W-1:0]  ent_line,
  output logic [NUM_LD-1:0]             alloc,
  output logic [NUM_LD-1:0][SLOT_W-1:0] slot,
  output logic [NUM_LD-1:0][SLOT_W-1:0] rank,
  output logic [NUM_LD-1:0]             merge,
  output logic [NUM_LD-1:0]             drop
);
  always_comb begin
    logic [DEPTH-1:0]  taken;
    logic [SLOT_W-1:0] n;
    logic              dup, found;
    taken = '0;
    n     = '0;
    alloc = '0;
    slot  = '0;
    rank  = '0;
    merge = '0;
    drop  = '0;
    dup   = 1'b0;
    found = 1'b0;
    for (int p = 0; p < NUM_LD; p++) begin
      dup   = 1'b0;
      found = 1'b0;
      if (miss[p]) begin
        for (int e = 0; e < DEPTH; e++)
          if (live[e] && ent_line[e] == line[p]) dup = 1'b1;
        for (int q = 0; q < NUM_LD; q++)
          if (q < p && alloc[q] && line[q] == line[p]) dup = 1'b1;
        if (dup) merge[p] = 1'b1;
        else begin
          // entries freed this cycle are still live here, so never reused same-cycle
          for (int e = 0; e < DEPTH; e++)
            if (!found && !live[e] && !taken[e]) begin
              found   = 1'b1;
              slot[p] = SLOT_W'(e);
            end
          if (found) begin
            alloc[p]       = 1'b1;
            taken[slot[p]] = 1'b1;
            rank[p]        = n;
            n              = n + SLOT_W'(1);
          end else drop[p] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/dcache_ctrl.sv
// Load-side dcache controller: 0-cycle hit path, MSHR miss tracking, FIFO
// issue to memory, line fill + replay broadcast. Optional DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_pkg::*;
(
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_LD-1:0]                  ld_en,
  input  logic [NUM_LD-1:0][15:0]            ld_addr,
  output logic [NUM_LD-1:0]                  ld_hit,
  output logic [NUM_LD-1:0][63:0]            ld_data,
  output logic [NUM_LD-1:0][DC_IDX_W-1:0]    cm_rd_idx,
  output logic [NUM_LD-1:0][DC_TAG_W-1:0]    cm_rd_tag,
  input  logic [NUM_LD-1:0][63:0]            cm_rd_data,
  input  logic [NUM_LD-1:0]                  cm_rd_valid,
  output logic [NUM_WR-1:0]                  cm_wr_en,
  output logic [NUM_WR-1:0][DC_IDX_W-1:0]    cm_wr_idx,
  output logic [NUM_WR-1:0][DC_TAG_W-1:0]    cm_wr_tag,
  output logic [NUM_WR-1:0][63:0]            cm_wr_data,
  output logic [1:0]                         proc2mem_command,
  output logic [15:0]                        proc2mem_addr,
  input  logic [MEM_TAG_W-1:0]               mem2proc_response,
  input  logic [MEM_TAG_W-1:0]               mem2proc_tag,
  input  logic [63:0]                        mem2proc_data,
  output logic                               fill_valid,
  output logic [DC_IDX_W-1:0]                fill_idx
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]                        hit_cnt,
  output logic [31:0]                        miss_cnt,
  output logic [31:0]                        merge_cnt,
  output logic [31:0]                        drop_cnt
`endif
);
  logic [NUM_LD-1:0]                  miss, alloc, merge, drop;
  logic [NUM_LD-1:0][LINE_W-1:0]      ld_line;
  logic [NUM_LD-1:0][SLOT_W-1:0]      alloc_slot, alloc_rank;
  logic [MSHR_DEPTH-1:0]              live;
  logic [MSHR_DEPTH-1:0][LINE_W-1:0]  ent_line;
  mshr_entry_t [MSHR_DEPTH-1:0]       mshr, mshr_nxt;
  logic                               iss_vld, fill_hit;
  logic [SLOT_W-1:0]                  iss_slot, iss_age, fill_slot;
  logic [SLOT_W:0]                    live_cnt, base;

  for (genvar i = 0; i < NUM_LD; i++) begin : g_port
    logic [2:0] unused_off;
    assign cm_rd_idx[i] = ld_en[i] ? ld_addr[i][7:3]  : '0;
    assign cm_rd_tag[i] = ld_en[i] ? ld_addr[i][15:8] : '0;
    assign ld_hit[i]    = ld_en[i] & cm_rd_valid[i];
    assign ld_data[i]   = ld_hit[i] ? cm_rd_data[i] : '0;
    assign miss[i]      = ld_en[i] & ~cm_rd_valid[i];
    assign ld_line[i]   = ld_addr[i][15:3];
    assign unused_off   = ld_addr[i][2:0];
  end

  for (genvar e = 0; e < MSHR_DEPTH; e++) begin : g_ent
    assign live[e]     = mshr[e].state != MSHR_EMPTY;
    assign ent_line[e] = {mshr[e].tag, mshr[e].idx};
  end

  dcache_mshr_alloc #(
    .NUM_LD (NUM_LD),
    .DEPTH  (MSHR_DEPTH),
    .LINE_W (LINE_W),
    .SLOT_W (SLOT_W)
  ) u_alloc (
    .miss     (miss),
    .line     (ld_line),
    .live     (live),
    .ent_line (ent_line),
    .alloc    (alloc),
    .slot     (alloc_slot),
    .rank     (alloc_rank),
    .merge    (merge),
    .drop     (drop)
  );

  always_comb begin
    iss_vld   = 1'b0;
    iss_slot  = '0;
    iss_age   = '0;
    fill_hit  = 1'b0;
    fill_slot = '0;
    for (int e = 0; e < MSHR_DEPTH; e++) begin
      if (mshr[e].state == MSHR_WAIT_ISSUE && (!iss_vld || mshr[e].age < iss_age)) begin
        iss_vld  = 1'b1;
        iss_slot = SLOT_W'(e);
        iss_age  = mshr[e].age;
      end
      // tag 0 means "no data"; stale tags simply find no WAIT_DATA match
      if (!fill_hit && mem2proc_tag != '0 && mshr[e].state == MSHR_WAIT_DATA &&
          mshr[e].mem_tag == mem2proc_tag) begin
        fill_hit  = 1'b1;
        fill_slot = SLOT_W'(e);
      end
    end
  end

  assign live_cnt = (SLOT_W+1)'(ones(8'(live)));
  assign base     = live_cnt - (SLOT_W+1)'(fill_hit);

  always_comb begin
    mshr_nxt = mshr;
    // closing the age gap left by the freed entry keeps ages dense
    for (int e = 0; e < MSHR_DEPTH; e++)
      if (fill_hit && live[e] && mshr[e].age > mshr[fill_slot].age)
        mshr_nxt[e].age = mshr[e].age - SLOT_W'(1);
    if (iss_vld && mem2proc_response != '0) begin
      mshr_nxt[iss_slot].state   = MSHR_WAIT_DATA;
      mshr_nxt[iss_slot].mem_tag = mem2proc_response;
    end
    if (fill_hit) mshr_nxt[fill_slot] = '0;
    for (int p = 0; p < NUM_LD; p++)
      if (alloc[p])
        mshr_nxt[alloc_slot[p]] = '{state:   MSHR_WAIT_ISSUE,
                                    tag:     ld_addr[p][15:8],
                                    idx:     ld_addr[p][7:3],
                                    mem_tag: '0,
                                    age:     SLOT_W'(base + (SLOT_W+1)'(alloc_rank[p]))};
  end

  always_ff @(posedge clock)
    if (reset) mshr <= '0;
    else       mshr <= mshr_nxt;

  always_comb begin
    proc2mem_command = iss_vld ? BUS_LOAD : BUS_NONE;
    proc2mem_addr    = iss_vld ? {mshr[iss_slot].tag, mshr[iss_slot].idx, 3'b000} : '0;
    cm_wr_en         = '0;
    cm_wr_idx        = '0;
    cm_wr_tag        = '0;
    cm_wr_data       = '0;
    cm_wr_en[0]      = fill_hit;
    if (fill_hit) begin
      cm_wr_idx[0]  = mshr[fill_slot].idx;
      cm_wr_tag[0]  = mshr[fill_slot].tag;
      cm_wr_data[0] = mem2proc_data;
    end
    fill_valid = fill_hit;
    fill_idx   = fill_hit ? mshr[fill_slot].idx : '0;
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clock)
    if (reset) begin
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      merge_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      hit_cnt   <= hit_cnt   + ones(8'(ld_hit));
      miss_cnt  <= miss_cnt  + ones(8'(miss));
      merge_cnt <= merge_cnt + ones(8'(merge));
      drop_cnt  <= drop_cnt  + ones(8'(drop));
    end
`else
  logic unused_stats;
  assign unused_stats = ^{merge, drop};
`endif
endmodule
